// File: rtl/slot_reader_pkg.sv
// Shared definitions for the slot reader: default geometry, stall limit and FSM state encoding.
package slot_reader_pkg;

    localparam int R_DEF         = 8;
    localparam int A_DEF         = 3;
    localparam int D_DEF         = 7;
    localparam int TO_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/slot_reader_if.sv
// Bus between the slot reader, the delay store it drains and the downstream consumer.
interface slot_reader_if
    import slot_reader_pkg::*;
#(
    parameter int R = R_DEF,
    parameter int A = A_DEF,
    parameter int D = D_DEF
) ();

    logic [R-1:0] reg_mc;
    logic [D-1:0] slot_data;
    logic [A-1:0] sel_mux;
    logic [D-1:0] out_data;
    logic [A-1:0] out_slot;
    logic         out_valid;
    logic         out_ready;
    logic         timeout_pulse;

    modport master (
        input  reg_mc, slot_data, out_ready,
        output sel_mux, out_data, out_slot, out_valid, timeout_pulse
    );

    modport slave (
        output reg_mc, slot_data, out_ready,
        input  sel_mux, out_data, out_slot, out_valid, timeout_pulse
    );

endinterface

// File: rtl/slot_reader_rr_pick.sv
// Combinational round-robin picker: first pending slot after i_last_slot, wrapping R-1 -> 1, slot 0 never chosen.
module rr_pick
    import slot_reader_pkg::*;
#(
    parameter int R = R_DEF,
    parameter int A = A_DEF
) (
    input  logic [R-1:0] i_flags,
    input  logic [A-1:0] i_last_slot,
    output logic         o_any,
    output logic [A-1:0] o_slot
);

    logic [A-1:0] w_cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_any  = 1'b0;
        o_slot = '0;
        w_cand = '0;
        for (int i = 1; i < R; i++) begin
            // Candidates cycle through 1..R-1 only, starting just after the last slot served.
            w_cand = A'(((int'(i_last_slot) + i - 1) % (R - 1)) + 1);
            if (!o_any && i_flags[w_cand]) begin
                o_any  = 1'b1;
                o_slot = w_cand;
            end
        end
    end

endmodule

// File: rtl/slot_reader.sv
// Drains pending slots of a delay store one word at a time with a one-cycle read acknowledge.
// Optional stall timeout compiled in with `define SLOT_READER_TIMEOUT_EN.
module slot_reader
    import slot_reader_pkg::*;
#(
    parameter int R         = R_DEF,
    parameter int A         = A_DEF,
    parameter int D         = D_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    slot_reader_if.master bus
);

    state_t       r_state;
    state_t       w_next;
    logic [A-1:0] r_last;
    logic [A-1:0] r_pick;
    logic [D-1:0] r_data;
    logic [A-1:0] r_slot;
    logic         w_any;
    logic [A-1:0] w_pick_slot;
    logic         w_load;
    logic         w_expire;

    rr_pick #(.R(R), .A(A)) u_pick (
        .i_flags    (bus.reg_mc),
        .i_last_slot(r_last),
        .o_any      (w_any),
        .o_slot     (w_pick_slot)
    );

`ifdef SLOT_READER_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] r_stall;
    logic          r_timeout;

    assign w_expire = (r_state == ST_VALID) && !bus.out_ready && (r_stall == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if ((r_state == ST_VALID) && !bus.out_ready && !w_expire)
                r_stall <= r_stall + 1'b1;
            else
                r_stall <= '0;
        end
    end

    assign bus.timeout_pulse = r_timeout;
`else
    assign w_expire          = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // sel_mux is driven only in READ, which always lasts one cycle: that pulse is the store's acknowledge.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        bus.sel_mux   = '0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_READ;
                    w_load = 1'b1;
                end
            end
            ST_READ: begin
                bus.sel_mux = r_pick;
                w_next      = ST_VALID;
            end
            ST_VALID: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = w_any ? ST_READ : ST_IDLE;
                    w_load = w_any;
                end else if (w_expire) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pick <= '0;
            r_last <= A'(R - 1);
            r_data <= '0;
            r_slot <= '0;
        end else begin
            if (w_load) r_pick <= w_pick_slot;
            if (r_state == ST_READ) begin
                r_data <= bus.slot_data;
                r_slot <= r_pick;
                r_last <= r_pick;
            end
        end
    end

    assign bus.out_data = r_data;
    assign bus.out_slot = r_slot;

endmodule

// File: tb/tb_slot_reader.sv
// Self-checking bench for slot_reader: directed corner cases plus randomized traffic against a transaction-level model.
module tb_slot_reader;
    import slot_reader_pkg::*;

    localparam int R = 8;
    localparam int A = 3;
    localparam int D = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slot_reader_if #(.R(R), .A(A), .D(D)) bus ();

    // Store model: read data is a combinational lookup of the selected slot.
    logic [D-1:0] mem [R];
    assign bus.slot_data = mem[bus.sel_mux];

    slot_reader #(.R(R), .A(A), .D(D), .TO_CYCLES(255)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.reg_mc    = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Next pending slot after 'last', stepping 1..7 with wrap; 0 when nothing pending.
    function automatic int rr_ref(input logic [7:0] f, input int last);
        int s = last;
        for (int k = 0; k < R - 1; k++) begin
            s = (s == R - 1) ? 1 : s + 1;
            if (f[s[A-1:0]]) return s;
        end
        return 0;
    endfunction

    typedef struct {
        int           slot;
        logic [D-1:0] data;
    } word_t;

    initial begin
        int busy;
        int e_sel [8];
        int e_ov  [8];
        int n_ov, n_to, to_at, first_drop;
        logic [7:0] flags, prev_flags;
        int m_last, prev_sel, exp_sel, s;
        bit prev_ov, prev_rdy, dec_prev, exp_ov, rdy;
        word_t q[$];
        word_t w;

        for (int i = 0; i < R; i++) mem[i] = '0;

        // Reset values, empty flags, slot 0 alone.
        do_reset();
        check("rst_sel",   32'(bus.sel_mux),       0);
        check("rst_valid", 32'(bus.out_valid),     0);
        check("rst_data",  32'(bus.out_data),      0);
        check("rst_slot",  32'(bus.out_slot),      0);
        check("rst_to",    32'(bus.timeout_pulse), 0);
        bus.out_ready = 1'b1;
        busy = 0;
        repeat (6) begin
            tick();
            if (bus.sel_mux != 0 || bus.out_valid) busy++;
        end
        check("idle_empty", 32'(busy), 0);
        bus.reg_mc = 8'b0000_0001;
        busy = 0;
        repeat (6) begin
            tick();
            if (bus.sel_mux != 0 || bus.out_valid) busy++;
        end
        check("slot0_ignored", 32'(busy), 0);

        // Single read: one-cycle select, word presented two cycles after the flag.
        do_reset();
        mem[2]     = 7'h35;
        bus.reg_mc = 8'b0000_0100;
        tick();
        check("single_sel", 32'(bus.sel_mux),   2);
        check("single_ov0", 32'(bus.out_valid), 0);
        bus.reg_mc = '0;
        tick();
        check("single_sel_off", 32'(bus.sel_mux),   0);
        check("single_valid",   32'(bus.out_valid), 1);
        check("single_data",    32'(bus.out_data),  32'h35);
        check("single_slot",    32'(bus.out_slot),  2);
        bus.out_ready = 1'b1;
        tick();
        check("single_done", 32'(bus.out_valid), 0);

        // Held flags 1 and 7: alternating order, one word per two cycles.
        do_reset();
        mem[1]        = 7'h11;
        mem[7]        = 7'h77;
        bus.reg_mc    = 8'b1000_0010;
        bus.out_ready = 1'b1;
        e_sel = '{1, 0, 7, 0, 1, 0, 7, 0};
        e_ov  = '{0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_sel",   32'(bus.sel_mux),   32'(e_sel[i]));
            check("rr_valid", 32'(bus.out_valid), 32'(e_ov[i]));
            if (e_ov[i] != 0) check("rr_slot", 32'(bus.out_slot), 32'(e_sel[(i > 0) ? i - 1 : 0]));
        end

        // Downstream stall for 300 cycles.
        do_reset();
        mem[3]     = 7'h2a;
        bus.reg_mc = 8'b0000_1000;
        tick();
        bus.reg_mc = '0;
        tick();
        n_ov = 0; n_to = 0; to_at = -1; first_drop = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.out_valid) n_ov++;
            else if (first_drop < 0) first_drop = i;
            if (bus.timeout_pulse) begin
                n_to++;
                to_at = i;
            end
            tick();
        end
`ifdef SLOT_READER_TIMEOUT_EN
        check("stall_valid_cycles", 32'(n_ov),       255);
        check("stall_pulses",       32'(n_to),       1);
        check("stall_pulse_at",     32'(to_at),      255);
        check("stall_drop_at",      32'(first_drop), 255);
`else
        check("stall_valid_cycles", 32'(n_ov), 300);
        check("stall_pulses",       32'(n_to), 0);
`endif

        // Reset while presenting a word: word dropped, no re-read.
        do_reset();
        mem[5]     = 7'h5a;
        bus.reg_mc = 8'b0010_0000;
        tick();
        bus.reg_mc = '0;
        tick();
        check("mid_valid", 32'(bus.out_valid), 1);
        rst = 1'b0;
        tick();
        check("rstv_valid", 32'(bus.out_valid), 0);
        check("rstv_data",  32'(bus.out_data),  0);
        check("rstv_sel",   32'(bus.sel_mux),   0);
        check("rstv_slot",  32'(bus.out_slot),  0);
        rst  = 1'b1;
        busy = 0;
        repeat (5) begin
            tick();
            if (bus.sel_mux != 0 || bus.out_valid) busy++;
        end
        check("rstv_no_reissue", 32'(busy), 0);

        // Randomized traffic: store acks on select, random writes, random backpressure.
        do_reset();
        flags = '0; prev_flags = '0;
        m_last = R - 1; prev_sel = 0;
        prev_ov = 1'b0; prev_rdy = 1'b0; dec_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_sel != 0) flags[prev_sel[A-1:0]] = 1'b0;
            if ($urandom_range(2) == 0) begin
                s = $urandom_range(R - 1, 1);
                if (!flags[s[A-1:0]]) begin
                    mem[s]           = D'($urandom);
                    flags[s[A-1:0]]  = 1'b1;
                end
            end
            flags[0]      = 1'($urandom_range(1));
            rdy           = ($urandom_range(3) != 0);
            bus.reg_mc    = flags;
            bus.out_ready = rdy;

            exp_sel = dec_prev ? rr_ref(prev_flags, m_last) : 0;
            exp_ov  = (prev_sel != 0) || (prev_ov && !prev_rdy);
            check("rnd_sel",   32'(bus.sel_mux),   32'(exp_sel));
            check("rnd_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_sel != 0) begin
                q.push_back('{exp_sel, mem[exp_sel]});
                m_last = exp_sel;
            end
            if (exp_ov) begin
                if (q.size() == 0) begin
                    check("rnd_model_empty", 32'(1), 32'(0));
                end else begin
                    w = q[0];
                    check("rnd_data", 32'(bus.out_data), 32'(w.data));
                    check("rnd_slot", 32'(bus.out_slot), 32'(w.slot));
                    if (rdy) void'(q.pop_front());
                end
            end
            dec_prev   = (exp_sel == 0 && !exp_ov) || (exp_ov && rdy);
            prev_sel   = exp_sel;
            prev_ov    = exp_ov;
            prev_rdy   = rdy;
            prev_flags = flags;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
